// File: rtl/aes_pkg.sv
// Shared constants, FSM encoding and GF(2^8) helpers for the AES-128 inverse cipher.
// Byte n of a block is bits [8n+7:8n]; state row r, column c is byte 4c+r.
package aes_pkg;

  localparam int NR       = 10;
  localparam int NB       = 4;
  localparam int BLOCK_W  = 128;
  localparam int EXPKEY_W = 1408;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ROUND = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] p;
    acc = '0;
    p   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc ^= p;
      p = xtime(p);
    end
    return acc;
  endfunction

  function automatic logic [BLOCK_W-1:0] inv_shift_rows(input logic [BLOCK_W-1:0] s);
    logic [BLOCK_W-1:0] o;
    o = '0;
    for (int c = 0; c < NB; c++)
      for (int r = 0; r < 4; r++)
        o[8*(4*c+r) +: 8] = s[8*(4*((c - r + NB) % NB) + r) +: 8];
    return o;
  endfunction

  function automatic logic [BLOCK_W-1:0] inv_mix_columns(input logic [BLOCK_W-1:0] s);
    logic [BLOCK_W-1:0] o;
    logic [7:0]         row [4];
    logic [7:0]         acc;
    row = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    o   = '0;
    for (int c = 0; c < NB; c++)
      for (int r = 0; r < 4; r++) begin
        acc = '0;
        // Row r of the matrix is row 0 rotated right by r positions.
        for (int j = 0; j < 4; j++)
          acc ^= gf_mul(s[8*(4*c+j) +: 8], row[(j - r + 4) % 4]);
        o[8*(4*c+r) +: 8] = acc;
      end
    return o;
  endfunction

endpackage

// File: rtl/aes_inv_sbox.sv
// Combinational AES inverse S-box lookup, one byte in, one byte out.
module aes_inv_sbox (
  input  logic [7:0] i_a,
  output logic [7:0] o_y
);

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  assign o_y = INV_SBOX[i_a];

endmodule

// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES-128 inverse cipher: one inverse round per clock, valid/ready on both sides.
// The expanded key is read combinationally, so its source holds it until out_valid.
module aes_inv_cipher_iter #(
  parameter int NR = aes_pkg::NR
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [aes_pkg::BLOCK_W-1:0]   cypher_text,
  input  logic [aes_pkg::EXPKEY_W-1:0]  expanded_key,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [aes_pkg::BLOCK_W-1:0]   plain_text
);
  import aes_pkg::*;

  state_e               r_state;
  state_e               w_state_nxt;
  logic [3:0]           r_rnd;
  logic [3:0]           w_rnd_nxt;
  logic [BLOCK_W-1:0]   r_st;
  logic [BLOCK_W-1:0]   w_st_nxt;
  logic                 r_out_valid;
  logic                 w_out_valid_nxt;

  logic [BLOCK_W-1:0]   w_isr;
  logic [BLOCK_W-1:0]   w_isb;
  logic [BLOCK_W-1:0]   w_rk;
  logic [BLOCK_W-1:0]   w_ark;
  logic [BLOCK_W-1:0]   w_imc;
  logic [BLOCK_W-1:0]   w_rk_last;

  assign w_isr = inv_shift_rows(r_st);

  for (genvar b = 0; b < 16; b++) begin : g_sbox
    aes_inv_sbox u_inv_sbox (
      .i_a (w_isr[8*b +: 8]),
      .o_y (w_isb[8*b +: 8])
    );
  end

  // r_rnd never exceeds NR-1, so the slice stays inside the key vector.
  assign w_rk      = expanded_key[BLOCK_W*r_rnd +: BLOCK_W];
  assign w_rk_last = expanded_key[BLOCK_W*NR +: BLOCK_W];
  assign w_ark     = w_isb ^ w_rk;
  assign w_imc     = inv_mix_columns(w_ark);

  assign in_ready   = (r_state == S_IDLE) && !rst;
  assign out_valid  = r_out_valid;
  assign plain_text = r_st;

  always_comb begin
    // NOTE: every output of this block is defaulted first so no path leaves one unassigned (no latches).
    w_state_nxt     = r_state;
    w_rnd_nxt       = r_rnd;
    w_st_nxt        = r_st;
    w_out_valid_nxt = r_out_valid;
    unique case (r_state)
      S_IDLE: begin
        if (in_valid && in_ready) begin
          w_st_nxt    = cypher_text ^ w_rk_last;
          w_rnd_nxt   = 4'(NR - 1);
          w_state_nxt = S_ROUND;
        end
      end
      S_ROUND: begin
        if (r_rnd != 4'd0) begin
          w_st_nxt  = w_imc;
          w_rnd_nxt = r_rnd - 4'd1;
        end else begin
          // Final round skips InvMixColumns.
          w_st_nxt        = w_ark;
          w_out_valid_nxt = 1'b1;
          w_state_nxt     = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          w_out_valid_nxt = 1'b0;
          w_state_nxt     = S_IDLE;
        end
      end
      default: begin
        w_out_valid_nxt = 1'b0;
        w_state_nxt     = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      r_state     <= S_IDLE;
      r_rnd       <= '0;
      r_st        <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_rnd       <= w_rnd_nxt;
      r_st        <= w_st_nxt;
      r_out_valid <= w_out_valid_nxt;
    end
  end

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Self-checking bench for aes_inv_cipher_iter: an independent forward AES model produces
// ciphertexts, and a scoreboard queue holds the plaintext each accepted block must return.
module tb_aes_inv_cipher_iter;

  logic           clk;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [127:0]   cypher_text;
  logic [1407:0]  expanded_key;
  logic           out_valid;
  logic           out_ready;
  logic [127:0]   plain_text;

  aes_inv_cipher_iter dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .cypher_text  (cypher_text),
    .expanded_key (expanded_key),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .plain_text   (plain_text)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model (forward cipher + key schedule) ----------------
  logic [7:0] sb [256];

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    logic [7:0] b;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      b = inv;
      sb[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [1407:0] key_expand(input logic [127:0] key);
    logic [31:0]   w [44];
    logic [31:0]   t;
    logic [7:0]    rcon;
    logic [1407:0] ek;
    rcon = 8'h01;
    for (int k = 0; k < 4; k++) w[k] = key[32*k +: 32];
    for (int k = 4; k < 44; k++) begin
      t = w[k-1];
      if (k % 4 == 0) begin
        t = {t[7:0], t[31:8]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
        t[7:0] = t[7:0] ^ rcon;
        rcon = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
      end
      w[k] = w[k-4] ^ t;
    end
    for (int k = 0; k < 44; k++) ek[32*k +: 32] = w[k];
    return ek;
  endfunction

  function automatic logic [127:0] encrypt(input logic [127:0] pt, input logic [1407:0] ek);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [127:0] o;
    for (int n = 0; n < 16; n++) s[n] = pt[8*n +: 8] ^ ek[8*n +: 8];
    for (int rd = 1; rd <= 10; rd++) begin
      for (int n = 0; n < 16; n++) t[n] = sb[s[n]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) s[4*c+r] = t[4*((c + r) % 4) + r];
      if (rd < 10) begin
        for (int n = 0; n < 16; n++) t[n] = s[n];
        for (int c = 0; c < 4; c++)
          for (int r = 0; r < 4; r++)
            s[4*c+r] = gm(t[4*c + r], 8'h02) ^ gm(t[4*c + (r+1)%4], 8'h03)
                     ^ t[4*c + (r+2)%4] ^ t[4*c + (r+3)%4];
      end
      for (int n = 0; n < 16; n++) s[n] = s[n] ^ ek[128*rd + 8*n +: 8];
    end
    for (int n = 0; n < 16; n++) o[8*n +: 8] = s[n];
    return o;
  endfunction

  // ---------------- scoreboard monitor (samples on the falling edge) ----------------
  logic [127:0] exp_q [$];
  int  cyc      = 0;
  int  last_acc = 0;
  int  n_out    = 0;
  bit  gap_chk  = 1'b0;
  bit  have_prev = 1'b0;
  logic prev_ov = 1'b0;

  always @(negedge clk) begin
    logic [127:0] e;
    cyc++;
    if (rst) begin
      prev_ov = 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        if (gap_chk && have_prev) check("accept_gap", 128'(cyc - last_acc), 128'd12);
        have_prev = gap_chk;
        last_acc  = cyc;
      end
      // Counting the accept edge as edge 1, out_valid rises on edge 11.
      if (out_valid && !prev_ov) check("latency_edges", 128'(cyc - last_acc), 128'd11);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", 128'd1, 128'd0);
        end else begin
          e = exp_q.pop_front();
          check("plain_text", plain_text, e);
        end
        n_out++;
      end
      prev_ov = out_valid;
    end
  end

  // ---------------- driver helpers ----------------
  task automatic wait_accept(input int budget);
    bit got;
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      got = in_ready;
    end
    if (!got) check("accept_timeout", 128'd0, 128'd1);
  endtask

  task automatic send(input logic [127:0] ct, input logic [1407:0] ek, input logic [127:0] exp);
    exp_q.push_back(exp);
    cypher_text  = ct;
    expanded_key = ek;
    in_valid     = 1'b1;
    wait_accept(64);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      seen = out_valid;
    end
    if (!seen) check("out_timeout", 128'd0, 128'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  localparam logic [127:0] K1  = 128'h0f0e0d0c0b0a09080706050403020100;
  localparam logic [127:0] CT1 = 128'h5ac5b47080b7cdd830047b6ad8e0c469;
  localparam logic [127:0] PT1 = 128'hffeeddccbbaa99887766554433221100;
  localparam logic [127:0] K2  = 128'h100F0E0D0C0B0A090807060504030201;
  localparam logic [127:0] PT2 = 128'h54494D47206E616C6F4E20726F6E6F43;

  initial begin
    logic [1407:0] ek1, ek2, ekr;
    logic [127:0]  ct2, kr, ptr;
    int n0, bad_ov, bad_pt, bad_ir;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    cypher_text = '0; expanded_key = '0;
    build_sbox();
    ek1 = key_expand(K1);
    ek2 = key_expand(K2);
    ct2 = encrypt(PT2, ek2);

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 128'(in_ready), 128'd0);
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_plain_text", plain_text, 128'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("idle_in_ready", 128'(in_ready), 128'd1);
    @(posedge clk); #1;

    // FIPS-197 C.1 known answer
    out_ready = 1'b1;
    send(CT1, ek1, PT1);
    wait_out(40);
    @(posedge clk); #1;

    // Round trip through the forward model
    send(ct2, ek2, PT2);
    wait_out(40);
    @(posedge clk); #1;

    // Backpressure
    out_ready = 1'b0;
    send(CT1, ek1, PT1);
    wait_out(40);
    n0 = n_out; bad_ov = 0; bad_pt = 0; bad_ir = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b1) bad_ov++;
      if (plain_text !== PT1) bad_pt++;
      if (in_ready !== 1'b0) bad_ir++;
    end
    check("bp_out_valid_drops", 128'(bad_ov), 128'd0);
    check("bp_plain_text_changes", 128'(bad_pt), 128'd0);
    check("bp_in_ready_high", 128'(bad_ir), 128'd0);
    check("bp_no_transfer", 128'(n_out - n0), 128'd0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    check("bp_in_ready_after", 128'(in_ready), 128'd1);
    check("bp_out_valid_after", 128'(out_valid), 128'd0);
    check("bp_one_transfer", 128'(n_out - n0), 128'd1);
    @(posedge clk); #1;

    // Garbage in_valid during ROUND is ignored
    out_ready = 1'b1;
    n0 = n_out;
    send(CT1, ek1, PT1);
    for (int i = 0; i < 8; i++) begin
      in_valid    = (i % 2 == 0);
      cypher_text = {$urandom(), $urandom(), $urandom(), $urandom()};
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    wait_out(40);
    @(posedge clk); #1;
    repeat (15) @(negedge clk);
    check("ignored_one_transfer", 128'(n_out - n0), 128'd1);
    @(posedge clk); #1;

    // Reset while rnd == 5
    n0 = n_out;
    send(CT1, ek1, PT1);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("midrst_in_ready_forced", 128'(in_ready), 128'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    void'(exp_q.pop_back());
    @(negedge clk);
    check("midrst_out_valid", 128'(out_valid), 128'd0);
    check("midrst_plain_text", plain_text, 128'd0);
    check("midrst_in_ready", 128'(in_ready), 128'd1);
    repeat (20) @(negedge clk);
    check("midrst_no_output", 128'(n_out - n0), 128'd0);
    @(posedge clk); #1;
    send(ct2, ek2, PT2);
    wait_out(40);
    @(posedge clk); #1;

    // Back-to-back random blocks, in_valid held high
    gap_chk  = 1'b1;
    in_valid = 1'b1;
    for (int b = 0; b < 8; b++) begin
      kr  = {$urandom(), $urandom(), $urandom(), $urandom()};
      ptr = {$urandom(), $urandom(), $urandom(), $urandom()};
      ekr = key_expand(kr);
      exp_q.push_back(ptr);
      cypher_text  = encrypt(ptr, ekr);
      expanded_key = ekr;
      wait_accept(64);
      wait_out(40);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    gap_chk  = 1'b0;
    repeat (5) @(negedge clk);
    check("queue_drained", 128'(exp_q.size()), 128'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
